sp_ram_bist: RTL and testbench



---
 rtl/sp_ram_bist_if.sv | 16 +
 rtl/sp_ram_bist.sv | 197 +++++++++++++++++++
 tb/tb_sp_ram_bist.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_bist_if.sv
// Single-port SRAM request bus: en/addr/wdata/we/be out, rdata back one cycle
// after a read request. The BIST is the master; the RAM (or its model) is the slave.
interface sp_ram_bist_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic                    en;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    we;
   logic [DATA_WIDTH/8-1:0] be;

   modport master (output en, addr, wdata, we, be, input rdata);
   modport slave  (input en, addr, wdata, we, be, output rdata);
endinterface

// File: rtl/sp_ram_bist.sv
// Memory self-test initiator. It writes a generated pattern over a word-aligned
// region, reads the region back, and compares each returned word.
// Bus protocol: a request is issued in every cycle in which en=1 (there is no
// back-pressure). A read issued in cycle t returns rdata in cycle t+1.
module sp_ram_bist #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [ADDR_WIDTH-2:0] num_words_i,
   input  logic [1:0]            pattern_sel_i,
   input  logic [DATA_WIDTH-1:0] seed_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic [2:0]            state_o,
   sp_ram_bist_if.master         ram
);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-2:0] IDX_ONE   = (ADDR_WIDTH-1)'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [ADDR_WIDTH-2:0]   num_q;
   logic [ADDR_WIDTH-2:0]   idx_q;
   logic [1:0]              sel_q;
   logic [DATA_WIDTH-1:0]   seed_q;
   logic [DATA_WIDTH-1:0]   lfsr_q;
   logic [DATA_WIDTH-1:0]   pat_q;      // pattern of the word on the bus this cycle
   logic                    cmp_vld;    // a read was issued last cycle
   logic [DATA_WIDTH-1:0]   cmp_exp;
   logic [ADDR_WIDTH-1:0]   cmp_addr;

   logic [ADDR_WIDTH-1:0]   nxt_addr;
   logic [DATA_WIDTH-1:0]   nxt_lfsr;
   logic                    last_word;
   logic                    mism;
   logic [ADDR_WIDTH-1:0]   start_base;

   function automatic logic [DATA_WIDTH-1:0] lfsr_init(input logic [DATA_WIDTH-1:0] seed);
      return (seed == '0) ? DATA_WIDTH'(1) : seed;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] gen_pat(input logic [1:0]            sel,
                                                     input logic [DATA_WIDTH-1:0] seed,
                                                     input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic                  odd,
                                                     input logic [DATA_WIDTH-1:0] lfsr);
      case (sel)
         2'd0:    return seed;
         2'd1:    return DATA_WIDTH'(addr) ^ seed;
         2'd2:    return odd ? ~seed : seed;
         default: return lfsr;
      endcase
   endfunction

   // Next-word address/LFSR, end-of-phase detect and read-back compare
   always_comb begin
      nxt_addr   = ram.addr + WORD_STEP;
      nxt_lfsr   = {1'b0, lfsr_q[DATA_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      last_word  = (idx_q == num_q - IDX_ONE);
      mism       = cmp_vld && (ram.rdata != cmp_exp);
      start_base = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
   end

   assign state_o = state;

   // Test sequencer: state, bus outputs, compare pipeline and result registers
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state            <= S_IDLE;
         base_q           <= '0;
         num_q            <= '0;
         idx_q            <= '0;
         sel_q            <= '0;
         seed_q           <= '0;
         lfsr_q           <= '0;
         pat_q            <= '0;
         cmp_vld          <= 1'b0;
         cmp_exp          <= '0;
         cmp_addr         <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         pass_o           <= 1'b0;
         err_cnt_o        <= '0;
         first_err_addr_o <= '0;
         ram.en           <= 1'b0;
         ram.we           <= 1'b0;
         ram.be           <= '0;
         ram.addr         <= '0;
         ram.wdata        <= '0;
      end else if (abort_i && state != S_IDLE) begin
         // Abort drops the bus and discards any read still awaiting compare
         state     <= S_IDLE;
         cmp_vld   <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         pass_o    <= 1'b0;
         ram.en    <= 1'b0;
         ram.we    <= 1'b0;
         ram.be    <= '0;
         ram.wdata <= '0;
      end else begin
         done_o  <= 1'b0;
         cmp_vld <= 1'b0;
         if (mism) begin
            if (err_cnt_o == '0) first_err_addr_o <= cmp_addr;
            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_ONE;
         end
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  base_q           <= start_base;
                  num_q            <= num_words_i;
                  sel_q            <= pattern_sel_i;
                  seed_q           <= seed_i;
                  idx_q            <= '0;
                  lfsr_q           <= lfsr_init(seed_i);
                  err_cnt_o        <= '0;
                  first_err_addr_o <= '0;
                  pass_o           <= 1'b0;
                  if (num_words_i == '0) begin
                     state  <= S_DONE;
                     done_o <= 1'b1;
                     pass_o <= 1'b1;
                  end else begin
                     state     <= S_WRITE;
                     busy_o    <= 1'b1;
                     pat_q     <= gen_pat(pattern_sel_i, seed_i, start_base, 1'b0, lfsr_init(seed_i));
                     ram.wdata <= gen_pat(pattern_sel_i, seed_i, start_base, 1'b0, lfsr_init(seed_i));
                     ram.en    <= 1'b1;
                     ram.we    <= 1'b1;
                     ram.be    <= '1;
                     ram.addr  <= start_base;
                  end
               end
            end
            S_WRITE: begin
               if (last_word) begin
                  // Restart the pattern generator so reads expect what was written
                  state     <= S_READ;
                  idx_q     <= '0;
                  lfsr_q    <= lfsr_init(seed_q);
                  pat_q     <= gen_pat(sel_q, seed_q, base_q, 1'b0, lfsr_init(seed_q));
                  ram.we    <= 1'b0;
                  ram.wdata <= '0;
                  ram.addr  <= base_q;
               end else begin
                  idx_q     <= idx_q + IDX_ONE;
                  lfsr_q    <= nxt_lfsr;
                  pat_q     <= gen_pat(sel_q, seed_q, nxt_addr, ~idx_q[0], nxt_lfsr);
                  ram.wdata <= gen_pat(sel_q, seed_q, nxt_addr, ~idx_q[0], nxt_lfsr);
                  ram.addr  <= nxt_addr;
               end
            end
            S_READ: begin
               cmp_vld  <= 1'b1;
               cmp_exp  <= pat_q;
               cmp_addr <= ram.addr;
               if (last_word) begin
                  state  <= S_DRAIN;
                  ram.en <= 1'b0;
                  ram.be <= '0;
               end else begin
                  idx_q    <= idx_q + IDX_ONE;
                  lfsr_q   <= nxt_lfsr;
                  pat_q    <= gen_pat(sel_q, seed_q, nxt_addr, ~idx_q[0], nxt_lfsr);
                  ram.addr <= nxt_addr;
               end
            end
            S_DRAIN: begin
               // The last word is compared this cycle, so fold it into pass
               state  <= S_DONE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
               pass_o <= (err_cnt_o == '0) && !mism;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp_ram_bist.sv
// Directed bench for sp_ram_bist with a behavioural single-port RAM that can
// corrupt selected read words.
module tb_sp_ram_bist;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        start_i;
   logic        abort_i;
   logic [15:0] base_addr_i;
   logic [14:0] num_words_i;
   logic [1:0]  pattern_sel_i;
   logic [31:0] seed_i;
   logic        busy_o;
   logic        done_o;
   logic        pass_o;
   logic [15:0] err_cnt_o;
   logic [15:0] first_err_addr_o;
   logic [2:0]  state_o;

   int total = 0;
   int bad   = 0;

   logic [15:0] wr_a[$];
   logic [31:0] wr_d[$];
   logic [15:0] rd_a[$];
   logic [31:0] exp_q[$];
   int          done_cnt = 0;
   int          be_bad   = 0;
   logic        corrupt  = 1'b0;
   logic [31:0] mem [0:16383];

   sp_ram_bist_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) ram_bus ();

   sp_ram_bist #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk              (clk),
      .rstn_i           (rstn_i),
      .start_i          (start_i),
      .abort_i          (abort_i),
      .base_addr_i      (base_addr_i),
      .num_words_i      (num_words_i),
      .pattern_sel_i    (pattern_sel_i),
      .seed_i           (seed_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .pass_o           (pass_o),
      .err_cnt_o        (err_cnt_o),
      .first_err_addr_o (first_err_addr_o),
      .state_o          (state_o),
      .ram              (ram_bus.master)
   );

   // clock
   always #5 clk = ~clk;

   // RAM model with optional corruption of reads at 0x108 and 0x10C
   always @(posedge clk) begin
      if (ram_bus.en && ram_bus.we) mem[ram_bus.addr[15:2]] <= ram_bus.wdata;
      if (ram_bus.en && !ram_bus.we) begin
         if (corrupt && ram_bus.addr == 16'h0108)
            ram_bus.rdata <= mem[ram_bus.addr[15:2]] ^ 32'h0000_0008;
         else if (corrupt && ram_bus.addr == 16'h010C)
            ram_bus.rdata <= mem[ram_bus.addr[15:2]] ^ 32'h0000_0001;
         else
            ram_bus.rdata <= mem[ram_bus.addr[15:2]];
      end
   end

   // bus monitor
   always @(posedge clk) begin
      if (ram_bus.en) begin
         if (ram_bus.be !== 4'hF) be_bad++;
         if (ram_bus.we) begin
            wr_a.push_back(ram_bus.addr);
            wr_d.push_back(ram_bus.wdata);
         end else begin
            rd_a.push_back(ram_bus.addr);
         end
      end
      if (done_o) done_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one start pulse and wait (bounded) for done_o; lat = cycles after start
   task automatic run_test(input logic [15:0] base, input logic [14:0] n,
                           input logic [1:0] sel, input logic [31:0] seed, output int lat);
      wr_a.delete();
      wr_d.delete();
      rd_a.delete();
      base_addr_i   = base;
      num_words_i   = n;
      pattern_sel_i = sel;
      seed_i        = seed;
      start_i       = 1'b1;
      step();
      start_i = 1'b0;
      lat     = -1;
      for (int c = 1; c <= 300; c++) begin
         if (done_o) begin
            lat = c;
            break;
         end
         step();
      end
   endtask

   int lat;
   int snap;
   logic [31:0] lfsr_tab [0:7];

   initial begin
      lfsr_tab[0] = 32'h0000_0001; lfsr_tab[1] = 32'h8020_0003;
      lfsr_tab[2] = 32'hC030_0002; lfsr_tab[3] = 32'h6018_0001;
      lfsr_tab[4] = 32'hB02C_0003; lfsr_tab[5] = 32'hD836_0002;
      lfsr_tab[6] = 32'h6C1B_0001; lfsr_tab[7] = 32'hB62D_8003;

      // reset
      rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      base_addr_i = '0; num_words_i = '0; pattern_sel_i = '0; seed_i = '0;
      ram_bus.rdata = '0;
      step(); step();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_en", 32'(ram_bus.en), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_pass", 32'(pass_o), 32'd0);
      chk("rst_err", 32'(err_cnt_o), 32'd0);
      chk("rst_first", 32'(first_err_addr_o), 32'd0);
      rstn_i = 1'b1;
      step();

      // constant pattern, clean RAM
      run_test(16'h0100, 15'd4, 2'd0, 32'hA5A5_A5A5, lat);
      chk("t1_lat", 32'(lat), 32'd10);
      chk("t1_pass", 32'(pass_o), 32'd1);
      chk("t1_err", 32'(err_cnt_o), 32'd0);
      chk("t1_busy_done", 32'(busy_o), 32'd0);
      chk("t1_nwr", 32'(wr_a.size()), 32'd4);
      chk("t1_nrd", 32'(rd_a.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_wa", 32'(wr_a[i]), 32'h100 + 32'(4 * i));
         chk("t1_wd", wr_d[i], 32'hA5A5_A5A5);
         chk("t1_ra", 32'(rd_a[i]), 32'h100 + 32'(4 * i));
      end
      step();
      chk("t1_pass_hold", 32'(pass_o), 32'd1);
      chk("t1_idle", 32'(state_o), 32'd0);
      chk("t1_done_pulse", 32'(done_o), 32'd0);

      // same test with two corrupted reads
      corrupt = 1'b1;
      run_test(16'h0100, 15'd4, 2'd0, 32'hA5A5_A5A5, lat);
      chk("t2_lat", 32'(lat), 32'd10);
      chk("t2_err", 32'(err_cnt_o), 32'd2);
      chk("t2_first", 32'(first_err_addr_o), 32'h108);
      chk("t2_pass", 32'(pass_o), 32'd0);
      corrupt = 1'b0;
      step();

      // address pattern with wrap past 0xFFFF; low base bits ignored
      run_test(16'hFFFB, 15'd4, 2'd1, 32'h0, lat);
      exp_q = '{32'h0000_FFF8, 32'h0000_FFFC, 32'h0000_0000, 32'h0000_0004};
      chk("t3_lat", 32'(lat), 32'd10);
      chk("t3_pass", 32'(pass_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("t3_wa", 32'(wr_a[i]), exp_q[i]);
         chk("t3_wd", wr_d[i], exp_q[i]);
         chk("t3_ra", 32'(rd_a[i]), exp_q[i]);
      end
      step();

      // checkerboard
      run_test(16'h0040, 15'd4, 2'd2, 32'h0F0F_0F0F, lat);
      exp_q = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
      chk("t4_pass", 32'(pass_o), 32'd1);
      for (int i = 0; i < 4; i++) chk("t4_wd", wr_d[i], exp_q[i]);
      step();

      // zero-length test
      snap = done_cnt;
      run_test(16'h0200, 15'd0, 2'd0, 32'h1234_5678, lat);
      chk("t5_lat_in_window", 32'(lat >= 1 && lat <= 2), 32'd1);
      chk("t5_pass", 32'(pass_o), 32'd1);
      chk("t5_no_bus", 32'(wr_a.size() + rd_a.size()), 32'd0);
      chk("t5_busy", 32'(busy_o), 32'd0);
      step(); step();
      chk("t5_one_done", 32'(done_cnt - snap), 32'd1);

      // LFSR with zero seed
      run_test(16'h0400, 15'd8, 2'd3, 32'h0, lat);
      chk("t6_lat", 32'(lat), 32'd18);
      chk("t6_pass", 32'(pass_o), 32'd1);
      chk("t6_nwr", 32'(wr_d.size()), 32'd8);
      for (int i = 0; i < 8; i++) chk("t6_wd", wr_d[i], lfsr_tab[i]);
      step();

      // abort on the third read cycle
      base_addr_i = 16'h0200; num_words_i = 15'd4; pattern_sel_i = 2'd0; seed_i = 32'h5555_AAAA;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("t7_busy", 32'(busy_o), 32'd1);
      for (int c = 1; c < 7; c++) step();
      chk("t7_rd3_en", 32'(ram_bus.en && !ram_bus.we), 32'd1);
      chk("t7_rd3_addr", 32'(ram_bus.addr), 32'h208);
      snap = done_cnt;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("t7_en", 32'(ram_bus.en), 32'd0);
      chk("t7_busy_off", 32'(busy_o), 32'd0);
      chk("t7_state", 32'(state_o), 32'd0);
      chk("t7_pass", 32'(pass_o), 32'd0);
      for (int c = 0; c < 10; c++) step();
      chk("t7_no_done", 32'(done_cnt - snap), 32'd0);
      run_test(16'h0200, 15'd4, 2'd0, 32'h5555_AAAA, lat);
      chk("t7_rerun_lat", 32'(lat), 32'd10);
      chk("t7_rerun_pass", 32'(pass_o), 32'd1);
      step();

      // reset in the middle of the write phase
      base_addr_i = 16'h0300; num_words_i = 15'd8; pattern_sel_i = 2'd1; seed_i = 32'hDEAD_BEEF;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step(); step();
      snap = done_cnt;
      rstn_i = 1'b0;
      #1;
      chk("t8_en", 32'(ram_bus.en), 32'd0);
      chk("t8_busy", 32'(busy_o), 32'd0);
      chk("t8_state", 32'(state_o), 32'd0);
      chk("t8_addr", 32'(ram_bus.addr), 32'd0);
      step();
      rstn_i = 1'b1;
      step();
      chk("t8_no_done", 32'(done_cnt - snap), 32'd0);
      run_test(16'h0300, 15'd8, 2'd1, 32'hDEAD_BEEF, lat);
      chk("t8_rerun_lat", 32'(lat), 32'd18);
      chk("t8_rerun_pass", 32'(pass_o), 32'd1);
      chk("t8_rerun_err", 32'(err_cnt_o), 32'd0);
      step();

      chk("be_all_ones", 32'(be_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
